multicycle_control_fsm: RTL and testbench

//  Control unit for the multicycle RV32I core. It is the sequential successor of the

---
 rtl/multicycle_control_fsm.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: walks each instruction through fetch, decode,
// execute, memory and writeback states and drives the datapath enables and mux selects.
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit SUPPORT_JALR    = 1'b1,
  parameter bit SUPPORT_UTYPE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal_instr,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALRADR, S_JALR,
    S_LUI, S_AUIPC, S_TRAP
  } state_t;

  state_t state, next;
  logic   rdy;
  logic   pcw, irw, mw, rw, done, illegal;

  // With the handshake disabled every access completes in one cycle.
  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // State register; reset drops any in-flight instruction back to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next;
  end

  // Sticky trap flag, set on the edge that enters TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    illegal_instr <= 1'b0;
    else if (state == S_DECODE && next == S_TRAP)  illegal_instr <= 1'b1;
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    next      = state;
    pcw       = 1'b0;
    irw       = 1'b0;
    mw        = 1'b0;
    rw        = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state)
      S_FETCH: begin
        ALUSrcB = 2'b10; ResultSrc = 2'b10;
        irw = rdy; pcw = rdy;
        if (rdy) next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: next = S_MEMADR;
          7'b0110011:             next = S_EXECR;
          7'b0010011:             next = S_EXECI;
          7'b1100011:             next = S_BRANCH;
          7'b1101111:             next = S_JAL;
          7'b1100111:             if (SUPPORT_JALR)  next = S_JALRADR; else illegal = 1'b1;
          7'b0110111:             if (SUPPORT_UTYPE) next = S_LUI;     else illegal = 1'b1;
          7'b0010111:             if (SUPPORT_UTYPE) next = S_AUIPC;   else illegal = 1'b1;
          default:                illegal = 1'b1;
        endcase
        if (illegal) begin
          if (TRAP_ON_ILLEGAL) next = S_TRAP;
          else begin done = 1'b1; next = S_FETCH; end
        end
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        next = (op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (rdy) next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01; rw = 1'b1; done = 1'b1;
        next = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1; mw = 1'b1; done = rdy;
        if (rdy) next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10; ALUOp = 2'b10;
        next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10;
        next = S_ALUWB;
      end
      S_ALUWB: begin
        rw = 1'b1; done = 1'b1;
        next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10; ALUOp = 2'b01;
        pcw = branch_cond; done = 1'b1;
        next = S_FETCH;
      end
      // JAL and JALR both load PC from ALUOut while the ALU forms OldPC+4 for the link.
      S_JAL, S_JALR: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; pcw = 1'b1;
        next = S_ALUWB;
      end
      S_JALRADR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        next = S_JALR;
      end
      S_LUI: begin
        ALUSrcA = 2'b11; ALUSrcB = 2'b01;
        next = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        next = S_ALUWB;
      end
      S_TRAP: next = S_TRAP;
      default: next = S_FETCH;
    endcase
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    case (op)
      7'b0100011:             ImmSrc = 3'b001;
      7'b1100011:             ImmSrc = 3'b010;
      7'b1101111:             ImmSrc = 3'b011;
      7'b0110111, 7'b0010111: ImmSrc = 3'b100;
      default:                ImmSrc = 3'b000;
    endcase
  end

  // Write strobes are held low for the whole reset assertion.
  assign PCWrite    = rst_n & pcw;
  assign IRWrite    = rst_n & irw;
  assign MemWrite   = rst_n & mw;
  assign RegWrite   = rst_n & rw;
  assign instr_done = rst_n & done;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for the multicycle control FSM: per-instruction expectations are
// queued when an instruction is launched and checked when instr_done retires it.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0110011;
  logic       branch_cond = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr, instr_done;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cycles;
    int irw;
    int pcw;
    int rw;
    int mw;
    int rw_cyc;
    int irw_cyc;
  } exp_t;

  exp_t sb[$];

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .branch_cond(branch_cond), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal_instr(illegal_instr),
    .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  // Reference timing of one instruction, written from the state-sequence table.
  function automatic exp_t model(input logic [6:0] o, input logic bc, input int fs, input int ms);
    exp_t e;
    e.irw = 1; e.pcw = 1; e.rw = 0; e.mw = 0; e.cycles = 0;
    case (o)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin e.cycles = 4; e.rw = 1; end
      7'b0000011: begin e.cycles = 5 + ms; e.rw = 1; end
      7'b0100011: begin e.cycles = 4 + ms; e.mw = 1 + ms; end
      7'b1100011: begin e.cycles = 3; e.pcw = 1 + int'(bc); end
      7'b1101111: begin e.cycles = 4; e.pcw = 2; e.rw = 1; end
      7'b1100111: begin e.cycles = 5; e.pcw = 2; e.rw = 1; end
      default: e.cycles = 0;
    endcase
    e.cycles += fs;
    e.rw_cyc  = (e.rw != 0) ? e.cycles : 0;
    e.irw_cyc = fs + 1;
    return e;
  endfunction

  // Launch one instruction from FETCH; mem_ready is low for fs FETCH cycles and for
  // ms cycles starting where a load/store would reach its memory state.
  task automatic run_instr(input string name, input logic [6:0] o, input logic bc,
                           input int fs, input int ms);
    exp_t e, got;
    int   cyc;
    bit   fin;
    sb.push_back(model(o, bc, fs, ms));
    got = '{default: 0};
    cyc = 0; fin = 0;
    op = o; branch_cond = bc;
    while (!fin && cyc < 60) begin
      @(negedge clk);
      cyc++;
      mem_ready = !((cyc <= fs) || (cyc >= fs + 4 && cyc <= fs + 3 + ms));
      #1;
      if (IRWrite)  begin got.irw++; got.irw_cyc = cyc; end
      if (PCWrite)  got.pcw++;
      if (MemWrite) got.mw++;
      if (RegWrite) begin got.rw++; got.rw_cyc = cyc; end
      if (instr_done) fin = 1;
    end
    got.cycles = cyc;
    e = sb.pop_front();
    checks++;
    if (!fin) begin
      errors++; $display("FAIL %s timeout: no instr_done after %0d cycles", name, cyc);
    end
    checks++;
    if (got.cycles !== e.cycles) begin
      errors++; $display("FAIL %s cycles: got %0d expected %0d", name, got.cycles, e.cycles);
    end
    checks++;
    if (got.irw !== e.irw || got.irw_cyc !== e.irw_cyc) begin
      errors++; $display("FAIL %s IRWrite: got %0d@%0d expected %0d@%0d", name,
                         got.irw, got.irw_cyc, e.irw, e.irw_cyc);
    end
    checks++;
    if (got.pcw !== e.pcw) begin
      errors++; $display("FAIL %s PCWrite count: got %0d expected %0d", name, got.pcw, e.pcw);
    end
    checks++;
    if (got.mw !== e.mw) begin
      errors++; $display("FAIL %s MemWrite count: got %0d expected %0d", name, got.mw, e.mw);
    end
    checks++;
    if (got.rw !== e.rw || got.rw_cyc !== e.rw_cyc) begin
      errors++; $display("FAIL %s RegWrite: got %0d@%0d expected %0d@%0d", name,
                         got.rw, got.rw_cyc, e.rw, e.rw_cyc);
    end
  endtask

  // Leave the FSM stalled in FETCH so the next run_instr starts at cycle 1.
  task automatic release_reset(input string name);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (IRWrite !== 1'b1 || ALUSrcB !== 2'b10 || ResultSrc !== 2'b10 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL %s fetch after reset: IRWrite=%b ALUSrcB=%b ResultSrc=%b RegWrite=%b expected 1 10 10 0",
                         name, IRWrite, ALUSrcB, ResultSrc, RegWrite);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op = 7'b0110011;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal_instr} !== 6'b0) begin
      errors++; $display("FAIL reset enables: got %b expected 000000",
                         {PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal_instr});
    end
    release_reset("reset");
  endtask

  task automatic test_immsrc();
    logic [6:0] ops [8] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                           7'b0110111, 7'b0010111, 7'b0110011, 7'b1100111};
    logic [2:0] imm [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b100, 3'b000, 3'b000};
    for (int i = 0; i < 8; i++) begin
      op = ops[i];
      #1;
      checks++;
      if (ImmSrc !== imm[i]) begin
        errors++; $display("FAIL immsrc op=%b: got %b expected %b", ops[i], ImmSrc, imm[i]);
      end
    end
  endtask

  task automatic test_alu();
    run_instr("add", 7'b0110011, 1'b0, 0, 0);
    run_instr("add_ready_ignored", 7'b0110011, 1'b0, 0, 1);
    run_instr("addi_fetch_stall", 7'b0010011, 1'b0, 1, 0);
    run_instr("lui", 7'b0110111, 1'b0, 0, 0);
    run_instr("auipc", 7'b0010111, 1'b0, 0, 0);
  endtask

  task automatic test_mem();
    run_instr("lw", 7'b0000011, 1'b0, 0, 0);
    run_instr("lw_stalls", 7'b0000011, 1'b0, 2, 3);
    run_instr("sw", 7'b0100011, 1'b0, 0, 0);
    run_instr("sw_stall", 7'b0100011, 1'b0, 0, 2);
  endtask

  task automatic test_branch_jump();
    run_instr("beq_not_taken", 7'b1100011, 1'b0, 0, 0);
    run_instr("beq_taken", 7'b1100011, 1'b1, 0, 0);
    run_instr("jal", 7'b1101111, 1'b0, 0, 0);
    run_instr("jalr", 7'b1100111, 1'b0, 0, 0);
  endtask

  task automatic test_trap();
    bit bad_en, bad_flag;
    op = 7'b1111111; mem_ready = 1'b1;
    @(negedge clk);      // FETCH
    @(negedge clk); #1;  // DECODE
    checks++;
    if (instr_done !== 1'b0 || illegal_instr !== 1'b0) begin
      errors++; $display("FAIL trap decode: instr_done=%b illegal_instr=%b expected 0 0",
                         instr_done, illegal_instr);
    end
    bad_en = 0; bad_flag = 0;
    repeat (8) begin
      @(negedge clk);
      mem_ready = ~mem_ready;
      #1;
      if (PCWrite || IRWrite || MemWrite || RegWrite || instr_done) bad_en = 1;
      if (illegal_instr !== 1'b1) bad_flag = 1;
    end
    checks++;
    if (bad_en) begin errors++; $display("FAIL trap enables: got an enable high expected none"); end
    checks++;
    if (bad_flag) begin errors++; $display("FAIL trap flag: illegal_instr dropped expected held 1"); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (illegal_instr !== 1'b0) begin
      errors++; $display("FAIL trap clear: illegal_instr=%b expected 0", illegal_instr);
    end
    release_reset("trap");
    run_instr("add_after_trap", 7'b0110011, 1'b0, 0, 0);
  endtask

  task automatic test_jalr_abort();
    op = 7'b1100111; mem_ready = 1'b1;
    @(negedge clk);      // FETCH
    @(negedge clk);      // DECODE
    @(negedge clk); #1;  // JALRADR
    checks++;
    if (ALUSrcA !== 2'b10 || ALUSrcB !== 2'b01 || PCWrite !== 1'b0 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL jalradr outputs: ALUSrcA=%b ALUSrcB=%b PCWrite=%b RegWrite=%b expected 10 01 0 0",
                         ALUSrcA, ALUSrcB, PCWrite, RegWrite);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({PCWrite, IRWrite, MemWrite, RegWrite, instr_done} !== 5'b0) begin
      errors++; $display("FAIL abort reset enables: got %b expected 00000",
                         {PCWrite, IRWrite, MemWrite, RegWrite, instr_done});
    end
    release_reset("abort");
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (PCWrite !== 1'b0 || RegWrite !== 1'b0 || ALUSrcB !== 2'b10 || AdrSrc !== 1'b0) begin
      errors++; $display("FAIL abort stays fetch: PCWrite=%b RegWrite=%b ALUSrcB=%b AdrSrc=%b expected 0 0 10 0",
                         PCWrite, RegWrite, ALUSrcB, AdrSrc);
    end
    run_instr("add_after_abort", 7'b0110011, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_immsrc();
    test_alu();
    test_mem();
    test_branch_jump();
    test_trap();
    test_jalr_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
